decode_ctrl: RTL and testbench
==============================

Name: decode_ctrl

Overview:
- Instruction decoder and sequencing FSM that sits directly upstream of the datapath top (regfile + alu32).
- Accepts one 32-bit instruction per handshake and splits it into register addresses, immediates and ALU opcodes.
- Drives the datapath's mux selects and its fetch/execute/writeback enables through a fixed 3-phase sequence.
- Captures the ALU overflow result and reports completion.

Parameters:
- DataSize, 32, instruction and datapath word width.
- AddrSize, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- instr  in  DataSize  instruction word.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- read_address1  out  AddrSize  ra field.
- read_address2  out  AddrSize  rb field.
- write_address  out  AddrSize  rt field.
- imm_5bit  out  5  instr[14:10].
- imm_15bit  out  15  instr[14:0].
- imm_20bit  out  20  instr[19:0].
- mux4to1_select  out  2  immediate select:
  - 00 = imm5, zero-extended.
  - 01 = imm15, sign-extended.
  - 10 = imm15, zero-extended.
  - 11 = imm20, sign-extended.
- imm_reg_select  out  1  1 = immediate, 0 = read_data2.
- mux2to1_select  out  1  1 = write immediate (MOVI), 0 = write ALU result.
- opcode  out  6  instr[30:25].
- sub_opcode  out  5  instr[4:0].
- enable_fetch  out  1  regfile read strobe.
- enable_execute  out  1  ALU strobe.
- enable_writeback  out  1  regfile write strobe.
- alu_overflow  in  1  from ALU.
- overflow_flag  out  1  sticky overflow.
- done  out  1  one-cycle retire pulse.
- illegal_instr  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Field map:
  - instr[31] must be 0.
  - opcode = [30:25], rt = [24:20], ra = [19:15], rb = [14:10], sub_op = [4:0].
- Legal opcodes and their selects:
  - ALU_1 (100000), sub_op in {00000 ADD, 00001 SUB, 00010 AND, 00011 XOR, 00100 OR}: imm_reg_select = 0.
  - ALU_1, sub_op in {01000 SLLI, 01001 SRLI, 01011 ROTRI}: imm_reg_select = 1, mux4to1_select = 00.
  - ADDI (101000): imm_reg_select = 1, select 01.
  - XORI (101011): imm_reg_select = 1, select 10.
  - ORI (101100): imm_reg_select = 1, select 10.
  - MOVI (100010): imm_reg_select = 1, select 11, mux2to1_select = 1.
  - mux2to1_select = 0 for everything except MOVI.
- Illegal: any other opcode, any other ALU_1 sub_op, or instr[31] = 1.
- FSM states: IDLE, FETCH, EXEC, WB, ERR.
  - IDLE: instr_ready = 1. Accept on instr_valid && instr_ready. Next state is FETCH if legal, ERR if illegal.
  - FETCH: enable_fetch = 1 for one cycle, then EXEC.
  - EXEC: enable_execute = 1 for one cycle, then WB.
  - WB: enable_writeback = 1 and done = 1 for one cycle. Sample alu_overflow; if 1, set overflow_flag. Then IDLE.
  - ERR: illegal_instr = 1 for one cycle. No enables asserted. Then IDLE.
- Decoded outputs are registered at accept and held stable from FETCH through WB/ERR. They hold their last values in IDLE.
- Latency: accept edge -> WB = 3 cycles. Throughput is one instruction per 4 cycles. instr_ready = 0 in every state except IDLE.
- instr_valid while not ready: ignored, no side effects.
- overflow_flag clears only on reset.
- Reset (rst = 0, asynchronous, including mid-sequence):
  - State -> IDLE.
  - All enables, done, illegal_instr, overflow_flag, selects, addresses, immediates and opcodes -> 0.
  - instr_ready -> 1 while rst is low.
  - No partial writeback may follow reset release.

Decomposition:
- Shared package holds:
  - opcode constants OP_ALU1, OP_ADDI, OP_XORI, OP_ORI, OP_MOVI;
  - sub_op constants SUB_ADD … SUB_ROTRI;
  - mux4to1_select encodings SEL_IMM5_ZE, SEL_IMM15_SE, SEL_IMM15_ZE, SEL_IMM20_SE;
  - FSM state encodings.
- One natural sub-module: decode_logic, purely combinational. It maps instr to {selects, legal}.
- decode_ctrl owns the FSM and the output registers.

Test Plan:
- ADD r3,r1,r2 (instr = 0x40308800):
  - addresses 1/2/3, imm_reg_select = 0, mux2to1_select = 0;
  - fetch/exec/wb each high exactly one cycle, on cycles +1/+2/+3 after accept;
  - done on +3.
- ADDI r4,r1,-1 (0x5040FFFF): imm_15bit = 0x7FFF, mux4to1_select = 01, imm_reg_select = 1, write_address = 4.
- MOVI r5,0x80000 (0x44580000): imm_20bit = 0x80000, mux4to1_select = 11, mux2to1_select = 1, imm_reg_select = 1.
- SLLI r6,r1,7 (0x40609C08): sub_opcode = 01000, imm_5bit = 7, mux4to1_select = 00. Drive alu_overflow = 1 in WB -> overflow_flag = 1 and stays set for the next ADD.
- Illegal 0x7E000000:
  - illegal_instr pulses on the cycle after accept;
  - no enable ever asserts;
  - instr_ready returns 1 two cycles after accept.
- Reset pulse during EXEC:
  - enables and overflow_flag drop asynchronously;
  - after release, the state is IDLE with instr_ready = 1 and no enable_writeback occurs;
  - instr_valid held high with no accept while busy produces no extra sequence.

Source files
------------

// File: rtl/decode_ctrl_pkg.sv
// Shared constants for the instruction decoder: opcode and sub-op values,
// immediate-select encodings, FSM state encodings and the decode result type.
package decode_ctrl_pkg;

  localparam logic [5:0] OP_ALU1 = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_XORI = 6'b101011;
  localparam logic [5:0] OP_ORI  = 6'b101100;
  localparam logic [5:0] OP_MOVI = 6'b100010;

  localparam logic [4:0] SUB_ADD   = 5'b00000;
  localparam logic [4:0] SUB_SUB   = 5'b00001;
  localparam logic [4:0] SUB_AND   = 5'b00010;
  localparam logic [4:0] SUB_XOR   = 5'b00011;
  localparam logic [4:0] SUB_OR    = 5'b00100;
  localparam logic [4:0] SUB_SLLI  = 5'b01000;
  localparam logic [4:0] SUB_SRLI  = 5'b01001;
  localparam logic [4:0] SUB_ROTRI = 5'b01011;

  localparam logic [1:0] SEL_IMM5_ZE  = 2'b00;
  localparam logic [1:0] SEL_IMM15_SE = 2'b01;
  localparam logic [1:0] SEL_IMM15_ZE = 2'b10;
  localparam logic [1:0] SEL_IMM20_SE = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef struct packed {
    logic [1:0] imm_sel;
    logic       imm_reg_sel;
    logic       wb_imm_sel;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/decode_ctrl_decode_logic.sv
// Combinational opcode/sub-op decoder: produces the datapath mux selects and
// a legality flag. Illegal encodings leave every select at zero.
module decode_logic
  import decode_ctrl_pkg::*;
(
  input  logic       top_bit_i,
  input  logic [5:0] opcode_i,
  input  logic [4:0] sub_op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    if (!top_bit_i) begin
      case (opcode_i)
        OP_ALU1: begin
          case (sub_op_i)
            SUB_ADD, SUB_SUB, SUB_AND, SUB_XOR, SUB_OR: begin
              dec_o.legal = 1'b1;
            end
            SUB_SLLI, SUB_SRLI, SUB_ROTRI: begin
              dec_o.legal       = 1'b1;
              dec_o.imm_reg_sel = 1'b1;
              dec_o.imm_sel     = SEL_IMM5_ZE;
            end
            default: ;
          endcase
        end
        OP_ADDI: begin
          dec_o.legal       = 1'b1;
          dec_o.imm_reg_sel = 1'b1;
          dec_o.imm_sel     = SEL_IMM15_SE;
        end
        OP_XORI, OP_ORI: begin
          dec_o.legal       = 1'b1;
          dec_o.imm_reg_sel = 1'b1;
          dec_o.imm_sel     = SEL_IMM15_ZE;
        end
        OP_MOVI: begin
          dec_o.legal       = 1'b1;
          dec_o.imm_reg_sel = 1'b1;
          dec_o.imm_sel     = SEL_IMM20_SE;
          dec_o.wb_imm_sel  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_ctrl.sv
// Instruction decoder and fixed FETCH/EXEC/WB sequencer in front of the
// regfile + ALU datapath; also keeps a sticky ALU overflow flag.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int DataSize = 32,
  parameter int AddrSize = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataSize-1:0] instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [AddrSize-1:0] read_address1,
  output logic [AddrSize-1:0] read_address2,
  output logic [AddrSize-1:0] write_address,
  output logic [4:0]          imm_5bit,
  output logic [14:0]         imm_15bit,
  output logic [19:0]         imm_20bit,
  output logic [1:0]          mux4to1_select,
  output logic                imm_reg_select,
  output logic                mux2to1_select,
  output logic [5:0]          opcode,
  output logic [4:0]          sub_opcode,
  output logic                enable_fetch,
  output logic                enable_execute,
  output logic                enable_writeback,
  input  logic                alu_overflow,
  output logic                overflow_flag,
  output logic                done,
  output logic                illegal_instr,
  output logic [2:0]          dbg_state_o
);

  // Handshake: an instruction transfers on a rising clk edge where
  // instr_valid && instr_ready. instr_ready is high only in IDLE, so a
  // valid offered while busy is simply not taken and has no effect.

  logic [2:0]          state_q, state_d;
  logic [AddrSize-1:0] ra_q, rb_q, rt_q;
  logic [4:0]          imm5_q, sub_q;
  logic [14:0]         imm15_q;
  logic [19:0]         imm20_q;
  logic [5:0]          op_q;
  logic [1:0]          sel4_q;
  logic                irs_q, m2_q, ovf_q;
  logic                accept;
  dec_t                dec;

  decode_logic u_decode (
    .top_bit_i (instr[31]),
    .opcode_i  (instr[30:25]),
    .sub_op_i  (instr[4:0]),
    .dec_o     (dec)
  );

  assign accept = instr_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = dec.legal ? ST_FETCH : ST_ERR;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rt_q    <= '0;
      imm5_q  <= '0;
      imm15_q <= '0;
      imm20_q <= '0;
      op_q    <= '0;
      sub_q   <= '0;
      sel4_q  <= '0;
      irs_q   <= 1'b0;
      m2_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ra_q    <= instr[19:15];
        rb_q    <= instr[14:10];
        rt_q    <= instr[24:20];
        imm5_q  <= instr[14:10];
        imm15_q <= instr[14:0];
        imm20_q <= instr[19:0];
        op_q    <= instr[30:25];
        sub_q   <= instr[4:0];
        sel4_q  <= dec.imm_sel;
        irs_q   <= dec.imm_reg_sel;
        m2_q    <= dec.wb_imm_sel;
      end
      // Overflow is only meaningful for the result being written back.
      if ((state_q == ST_WB) && alu_overflow) ovf_q <= 1'b1;
    end
  end

  assign instr_ready      = (state_q == ST_IDLE);
  assign enable_fetch     = (state_q == ST_FETCH);
  assign enable_execute   = (state_q == ST_EXEC);
  assign enable_writeback = (state_q == ST_WB);
  assign done             = (state_q == ST_WB);
  assign illegal_instr    = (state_q == ST_ERR);
  assign overflow_flag    = ovf_q;
  assign read_address1    = ra_q;
  assign read_address2    = rb_q;
  assign write_address    = rt_q;
  assign imm_5bit         = imm5_q;
  assign imm_15bit        = imm15_q;
  assign imm_20bit        = imm20_q;
  assign opcode           = op_q;
  assign sub_opcode       = sub_q;
  assign mux4to1_select   = sel4_q;
  assign imm_reg_select   = irs_q;
  assign mux2to1_select   = m2_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: a vector table walked through the full
// accept/FETCH/EXEC/WB sequence, plus reset-in-EXEC and busy-valid sequences.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  read_address1, read_address2, write_address;
  logic [4:0]  imm_5bit;
  logic [14:0] imm_15bit;
  logic [19:0] imm_20bit;
  logic [1:0]  mux4to1_select;
  logic        imm_reg_select, mux2to1_select;
  logic [5:0]  opcode;
  logic [4:0]  sub_opcode;
  logic        enable_fetch, enable_execute, enable_writeback;
  logic        alu_overflow = 1'b0;
  logic        overflow_flag, done, illegal_instr;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_fail = 0;

  decode_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .read_address1    (read_address1),
    .read_address2    (read_address2),
    .write_address    (write_address),
    .imm_5bit         (imm_5bit),
    .imm_15bit        (imm_15bit),
    .imm_20bit        (imm_20bit),
    .mux4to1_select   (mux4to1_select),
    .imm_reg_select   (imm_reg_select),
    .mux2to1_select   (mux2to1_select),
    .opcode           (opcode),
    .sub_opcode       (sub_opcode),
    .enable_fetch     (enable_fetch),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .alu_overflow     (alu_overflow),
    .overflow_flag    (overflow_flag),
    .done             (done),
    .illegal_instr    (illegal_instr),
    .dbg_state_o      (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (state=%0d)", dbg_state);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  ra, rb, rt;
    logic [1:0]  sel;
    logic        irs, m2, legal, noise, ovf_in, exp_ovf;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [31:0] i, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [4:0] rt, input logic [1:0] sel, input logic irs,
                              input logic m2, input logic legal, input logic noise,
                              input logic ovf_in, input logic exp_ovf);
    vec_t v;
    v.instr = i; v.ra = ra; v.rb = rb; v.rt = rt; v.sel = sel; v.irs = irs; v.m2 = m2;
    v.legal = legal; v.noise = noise; v.ovf_in = ovf_in; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (instr_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic chk_enables(input string nm, input logic f, input logic e, input logic w,
                             input logic d, input logic ill, input logic rdy);
    chk({nm, "_fetch"}, {31'd0, enable_fetch}, {31'd0, f});
    chk({nm, "_exec"}, {31'd0, enable_execute}, {31'd0, e});
    chk({nm, "_wb"}, {31'd0, enable_writeback}, {31'd0, w});
    chk({nm, "_done"}, {31'd0, done}, {31'd0, d});
    chk({nm, "_illegal"}, {31'd0, illegal_instr}, {31'd0, ill});
    chk({nm, "_ready"}, {31'd0, instr_ready}, {31'd0, rdy});
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    instr = v.instr;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rt", {27'd0, write_address}, {27'd0, v.rt});
    if (v.legal) begin
      chk_enables("p1", 1, 0, 0, 0, 0, 0);
      chk("ra", {27'd0, read_address1}, {27'd0, v.ra});
      chk("rb", {27'd0, read_address2}, {27'd0, v.rb});
      chk("sel4", {30'd0, mux4to1_select}, {30'd0, v.sel});
      chk("irs", {31'd0, imm_reg_select}, {31'd0, v.irs});
      chk("m2", {31'd0, mux2to1_select}, {31'd0, v.m2});
      chk("opcode", {26'd0, opcode}, {26'd0, v.instr[30:25]});
      chk("sub_op", {27'd0, sub_opcode}, {27'd0, v.instr[4:0]});
      chk("imm5", {27'd0, imm_5bit}, {27'd0, v.instr[14:10]});
      chk("imm15", {17'd0, imm_15bit}, {17'd0, v.instr[14:0]});
      chk("imm20", {12'd0, imm_20bit}, {12'd0, v.instr[19:0]});
      alu_overflow = v.noise;
      instr = ~v.instr;
      @(negedge clk);
      chk_enables("p2", 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk_enables("p3", 0, 0, 1, 1, 0, 0);
      chk("rt_hold", {27'd0, write_address}, {27'd0, v.rt});
      chk("sel4_hold", {30'd0, mux4to1_select}, {30'd0, v.sel});
      alu_overflow = v.ovf_in;
      @(negedge clk);
      alu_overflow = 1'b0;
      chk_enables("p4", 0, 0, 0, 0, 0, 1);
      chk("ovf_flag", {31'd0, overflow_flag}, {31'd0, v.exp_ovf});
    end else begin
      chk_enables("ill1", 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk_enables("ill2", 0, 0, 0, 0, 0, 1);
      chk("ill_ovf", {31'd0, overflow_flag}, {31'd0, v.exp_ovf});
    end
  endtask

  initial begin
    int n_f, n_w;
    tbl[0]  = mk(32'h40308800, 5'd1,  5'd2,  5'd3, 2'b00, 0, 0, 1, 1, 0, 0); // ADD
    tbl[1]  = mk(32'h5040FFFF, 5'd1,  5'd31, 5'd4, 2'b01, 1, 0, 1, 0, 0, 0); // ADDI
    tbl[2]  = mk(32'h44580000, 5'd16, 5'd0,  5'd5, 2'b11, 1, 1, 1, 0, 0, 0); // MOVI
    tbl[3]  = mk(32'h56219234, 5'd3,  5'd4,  5'd2, 2'b10, 1, 0, 1, 0, 0, 0); // XORI
    tbl[4]  = mk(32'h58740005, 5'd8,  5'd0,  5'd7, 2'b10, 1, 0, 1, 0, 0, 0); // ORI
    tbl[5]  = mk(32'h40952C01, 5'd10, 5'd11, 5'd9, 2'b00, 0, 0, 1, 1, 0, 0); // SUB
    tbl[6]  = mk(32'h40117C0B, 5'd2,  5'd31, 5'd1, 2'b00, 1, 0, 1, 0, 0, 0); // ROTRI
    tbl[7]  = mk(32'h40308802, 5'd1,  5'd2,  5'd3, 2'b00, 0, 0, 1, 0, 0, 0); // AND
    tbl[8]  = mk(32'h40609C08, 5'd1,  5'd7,  5'd6, 2'b00, 1, 0, 1, 0, 1, 1); // SLLI
    tbl[9]  = mk(32'h40308800, 5'd1,  5'd2,  5'd3, 2'b00, 0, 0, 1, 0, 0, 1); // ADD
    tbl[10] = mk(32'h7E000000, 5'd0,  5'd0,  5'd0, 2'b00, 0, 0, 0, 0, 0, 1); // bad op
    tbl[11] = mk(32'h40308805, 5'd1,  5'd2,  5'd3, 2'b00, 0, 0, 0, 0, 0, 1); // bad sub
    tbl[12] = mk(32'hC0308800, 5'd1,  5'd2,  5'd3, 2'b00, 0, 0, 0, 0, 0, 1); // bit31

    // Reset state
    repeat (2) @(negedge clk);
    chk_enables("rst", 0, 0, 0, 0, 0, 1);
    chk("rst_ovf", {31'd0, overflow_flag}, 32'd0);
    chk("rst_rt", {27'd0, write_address}, 32'd0);
    chk("rst_imm20", {12'd0, imm_20bit}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Asynchronous reset while in EXEC
    wait_ready();
    instr = 32'h40308800;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_exec", {31'd0, enable_execute}, 32'd1);
    chk("pre_rst_ovf", {31'd0, overflow_flag}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_enables("async_rst", 0, 0, 0, 0, 0, 1);
    chk("async_rst_ovf", {31'd0, overflow_flag}, 32'd0);
    chk("async_rst_rt", {27'd0, write_address}, 32'd0);
    chk("async_rst_irs", {31'd0, imm_reg_select}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_f = 0; n_w = 0;
    for (int c = 0; c < 6; c++) begin
      n_f += int'(enable_fetch);
      n_w += int'(enable_writeback);
      @(negedge clk);
    end
    chk("post_rst_wb_count", n_w, 32'd0);
    chk("post_rst_fetch_count", n_f, 32'd0);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);

    // instr_valid held high while busy must not start another sequence
    instr = 32'h40308800;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr = 32'h5040FFFF;
    n_f = 0; n_w = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        chk("busy_rt_hold", {27'd0, write_address}, 32'd3);
        chk("busy_ready", {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;
      end
      n_f += int'(enable_fetch);
      n_w += int'(enable_writeback);
      @(negedge clk);
    end
    chk("busy_fetch_count", n_f, 32'd1);
    chk("busy_wb_count", n_w, 32'd1);
    chk("busy_final_ready", {31'd0, instr_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
